// File: rtl/ysyx_040066_div_iter.sv
// ----------------------------------------------------------------------------
// ysyx_040066_div_iter
// Multi-cycle radix-2 restoring divider for the RV64M execute stage.
// Handles DIV/DIVU/REM/REMU and their W variants. Signed operands are turned
// into magnitudes, divided unsigned one bit per cycle, then sign-corrected.
//
// Ports:
//   clk        core clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort, back to IDLE next cycle, result discarded
//   in_valid   request valid          in_ready  high only in IDLE
//   src1_in    dividend               src2_in   divisor
//   ALUctr_in  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   is_w_in    32-bit W variant
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     quotient or remainder (holds its last value outside DONE)
//
// Build option: define DIV_FASTPATH_EN to skip the iteration loop for a zero
// divisor or signed overflow (result values are identical either way).
// ----------------------------------------------------------------------------
module ysyx_040066_div_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1_in,
    input  logic [XLEN-1:0] src2_in,
    input  logic [1:0]      ALUctr_in,
    input  logic            is_w_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]      op_r;
    logic            is_w_r;
    logic            sgn_r;
    logic            sign1_r;
    logic            sign2_r;
    logic            dz_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dsr_r;
    logic [CNT_W-1:0] cnt_r;

    // ---------------- operand preparation (IDLE) ----------------
    logic            op_signed;
    logic [XLEN-1:0] a_ext, b_ext;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] quo_init;
    logic            b_zero, ovf;
    logic            accept;

    assign op_signed = ~ALUctr_in[0];
    assign a_ext = is_w_in ? {{HALF{op_signed & src1_in[HALF-1]}}, src1_in[HALF-1:0]} : src1_in;
    assign b_ext = is_w_in ? {{HALF{op_signed & src2_in[HALF-1]}}, src2_in[HALF-1:0]} : src2_in;
    assign a_neg = op_signed & a_ext[XLEN-1];
    assign b_neg = op_signed & b_ext[XLEN-1];
    assign a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
    assign b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;
    // W ops run 32 iterations, so park the dividend in the upper half where
    // the shift loop pulls bits from the MSB.
    assign quo_init = is_w_in ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
    assign b_zero = (b_ext == '0);
    // Sign-extended -2^(n-1) / -1, which is the same 64-bit pattern test for W.
    assign ovf = op_signed && (b_ext == '1) &&
                 (is_w_in ? (a_ext == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}})
                          : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
    assign accept = (state == IDLE) && in_valid && !flush;

    // ---------------- one shift-subtract step (CALC) ----------------
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;
    logic [XLEN-1:0] rem_step, quo_step;

    assign rem_sh   = {rem_r, quo_r[XLEN-1]};
    assign rem_sub  = rem_sh - {1'b0, dsr_r};
    assign ge       = (rem_sh >= {1'b0, dsr_r});
    assign rem_step = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_step = {quo_r[XLEN-2:0], ge};

    // ---------------- sign fix and selection (FIX) ----------------
    logic [XLEN-1:0] q_fix, r_fix, sel, res_fix;

    assign q_fix   = (sgn_r && (sign1_r ^ sign2_r) && !dz_r) ? (~quo_r + 1'b1) : quo_r;
    assign r_fix   = (sgn_r && sign1_r) ? (~rem_r + 1'b1) : rem_r;
    assign sel     = op_r[1] ? r_fix : q_fix;
    assign res_fix = is_w_r ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) begin
`ifdef DIV_FASTPATH_EN
                state_nxt = (b_zero || ovf) ? FIX : CALC;
`else
                state_nxt = CALC;
`endif
            end
            CALC: if (cnt_r == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= '0;
            is_w_r  <= 1'b0;
            sgn_r   <= 1'b0;
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
            dz_r    <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
            dsr_r   <= '0;
            cnt_r   <= '0;
            result  <= '0;
        end else begin
            if (accept) begin
                op_r    <= ALUctr_in;
                is_w_r  <= is_w_in;
                sgn_r   <= op_signed;
                sign1_r <= a_neg;
                sign2_r <= b_neg;
                dz_r    <= b_zero;
                dsr_r   <= b_mag;
                cnt_r   <= is_w_in ? CNT_W'(HALF) : CNT_W'(XLEN);
`ifdef DIV_FASTPATH_EN
                // Preload exactly what the loop would have produced, so the
                // shared FIX logic yields the architected special result.
                if (b_zero) begin
                    quo_r <= '1;
                    rem_r <= a_mag;
                end else if (ovf) begin
                    quo_r <= a_mag;
                    rem_r <= '0;
                end else begin
                    quo_r <= quo_init;
                    rem_r <= '0;
                end
`else
                quo_r <= quo_init;
                rem_r <= '0;
`endif
            end else if (state == CALC && !flush) begin
                quo_r <= quo_step;
                rem_r <= rem_step;
                cnt_r <= cnt_r - 1'b1;
            end else if (state == FIX && !flush) begin
                result <= res_fix;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040066_div_iter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_040066_div_iter
// Randomized and directed bench for ysyx_040066_div_iter, compared against a
// plain-arithmetic model of the RISC-V division rules.
// ----------------------------------------------------------------------------
module tb_ysyx_040066_div_iter;

`ifdef DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] src1_in = '0;
    logic [63:0] src2_in = '0;
    logic [1:0]  ALUctr_in = '0;
    logic        is_w_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_040066_div_iter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1_in(src1_in), .src2_in(src2_in),
        .ALUctr_in(ALUctr_in), .is_w_in(is_w_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics with native SV arithmetic.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic w);
        logic sgn, want_rem;
        sgn = ~op[0];
        want_rem = op[1];
        if (w) begin
            logic [31:0] a32, b32, q32, r32;
            int sa, sb;
            a32 = a[31:0];
            b32 = b[31:0];
            sa = a32;
            sb = b32;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (sgn) begin
                q32 = sa / sb;
                r32 = sa % sb;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            return want_rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            logic [63:0] q, r;
            longint la, lb;
            la = a;
            lb = b;
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = 64'd0;
            end else if (sgn) begin
                q = la / lb;
                r = la % lb;
            end else begin
                q = a / b;
                r = a % b;
            end
            return want_rem ? r : q;
        end
    endfunction

    function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                      input logic [1:0] op, input logic w);
        if (w)
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Issue one request, wait for completion, hold for 'hold' cycles, accept.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic w, input int hold,
                          input bit do_accept);
        logic [63:0] exp;
        int exp_lat, lat;
        exp = model(a, b, op, w);
        exp_lat = (FAST && is_special(a, b, op, w)) ? 2 : (w ? 34 : 66);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        src1_in = a; src2_in = b; ALUctr_in = op; is_w_in = w; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1_in = {$urandom, $urandom};
        src2_in = {$urandom, $urandom};
        ALUctr_in = 2'($urandom);
        is_w_in = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, result, exp);
        end
        if (do_accept) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
            check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int seen;
        logic [63:0] a, b;
        logic [1:0] op;
        logic w;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("divu_100_7", 64'd100, 64'd7, 2'b01, 1'b0, 0, 1'b1);
        run_op("remu_100_7", 64'd100, 64'd7, 2'b11, 1'b0, 0, 1'b1);
        run_op("div_m7_2", -64'sd7, 64'd2, 2'b00, 1'b0, 0, 1'b1);
        run_op("rem_m7_2", -64'sd7, 64'd2, 2'b10, 1'b0, 0, 1'b1);
        run_op("divu_by0", 64'h1234, 64'd0, 2'b01, 1'b0, 0, 1'b1);
        run_op("remu_by0", 64'h1234, 64'd0, 2'b11, 1'b0, 0, 1'b1);
        run_op("div_ovf", 64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 0, 1'b1);
        run_op("rem_ovf", 64'h8000_0000_0000_0000, '1, 2'b10, 1'b0, 0, 1'b1);
        run_op("divuw_sext", 64'hFFFF_FFFF_8000_0000, 64'd1, 2'b01, 1'b1, 0, 1'b1);
        run_op("divw_ovf", 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 2'b00, 1'b1, 0, 1'b1);
        run_op("remw_by0", 64'h0000_0000_FFFF_FFF9, 64'hFFFF_0000_0000_0000, 2'b10, 1'b1, 0, 1'b1);
        run_op("hold5", 64'd1000003, 64'd17, 2'b00, 1'b0, 5, 1'b1);

        // Flush mid-CALC
        @(negedge clk);
        src1_in = 64'd12345; src2_in = 64'd3; ALUctr_in = 2'b01; is_w_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        src1_in = 64'd9; src2_in = 64'd0; ALUctr_in = 2'b01; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_idle_no_result", 64'(seen), 64'd0);

        // Async reset while in DONE
        run_op("pre_reset", 64'd77, 64'd5, 2'b01, 1'b0, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            w  = 1'($urandom);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom} >> $urandom_range(0, 63);
            case ($urandom_range(0, 5))
                0: b = w ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
                end
                2: a = a >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op("rand", a, b, op, w, $urandom_range(0, 2), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_040066_div_iter.md
Name: ysyx_040066_div_iter

Overview:
Multi-cycle iterative radix-2 integer divider for the RV64M execute stage. It covers DIV/DIVU/REM/REMU and the W variants, and is the inverse-operation companion of the pipelined Booth/Wallace multiplier in the same EXU.
- Signed operands are converted to magnitudes, divided unsigned by shift-subtract, then sign-fixed.
- Operation uses a valid/ready handshake, so the EXU stalls on in_ready/out_valid rather than on a fixed latency.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.
CNT_W, 7, iteration counter width (holds 0..64).

Ports:
clk  in  1  core clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort; returns to IDLE next cycle, result discarded.
in_valid  in  1  request valid.
in_ready  out  1  high only in IDLE.
src1_in  in  64  dividend.
src2_in  in  64  divisor.
ALUctr_in  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
is_w_in  in  1  32-bit W variant.
out_valid  out  1  result valid, held until accepted.
out_ready  in  1  consumer accepts result.
result  out  64  quotient or remainder.

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1, out_valid=0, result=0; counter and all datapath regs cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when in_valid&&in_ready.
  - Latch op, is_w and signedness (ALUctr_in[0]==0).
  - For W ops, operands are the low 32 bits, sign- or zero-extended per signedness.
  - Store |dividend| and |divisor| and both sign bits; load counter N (64, or 32 for W). Go to CALC.
- CALC:
  - Each cycle: rem={rem,quo_msb}; if rem>=divisor, subtract and shift in 1, else shift in 0. Counter decrements.
  - When the counter reaches 1, go to FIX.
- FIX (1 cycle):
  - Quotient is negated if signed and sign1!=sign2 and divisor!=0.
  - Remainder is negated if signed and the dividend is negative.
  - Select quotient (ALUctr[1]=0) or remainder; W ops sign-extend bit 31, including DIVUW/REMUW. Go to DONE.
- DONE: out_valid=1 with result stable. On out_ready go to IDLE; in_ready rises the next cycle, so there is no accept in the same cycle as completion.
- Latency: handshake at cycle t -> out_valid at t+N+2 (66 cycles for 64-bit, 34 for W).
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: quotient=all ones (sign-extended for W); remainder=dividend.
  - Signed overflow (-2^63/-1, or -2^31/-1 for W): quotient=dividend; remainder=0.
- flush:
  - Highest priority after reset. From any state go to IDLE; out_valid drops next cycle.
  - flush with in_valid in IDLE: the request is not accepted.
- in_valid while busy is ignored; the upstream holds it.
- Operand inputs are sampled only at acceptance; later changes have no effect.
- result holds its last value outside DONE; it is not cleared.

Optional Feature:
DIV_FASTPATH_EN
- Defined: a zero divisor or signed overflow detected in IDLE skips CALC. FIX loads the special result directly, so out_valid appears at t+2.
- Undefined: these cases run all N iterations and are corrected in FIX, so out_valid appears at t+N+2.
- Result values are identical in both builds.

Test Plan:
- DIVU 100/7, 64-bit -> result=14, out_valid exactly at t+66. Same operands with REMU -> 2.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU x/0 with x=0x1234 -> all ones; REMU -> 0x1234.
  - With DIV_FASTPATH_EN: out_valid at t+2.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
- DIVUW src1=0xFFFF_FFFF_8000_0000, src2=1 -> 0xFFFF_FFFF_8000_0000 (sign-extended), out_valid at t+34.
- Reset and flush:
  - Assert flush mid-CALC at cycle t+10 -> IDLE at t+11, no out_valid, in_ready=1.
  - Drop rst_n asynchronously in DONE -> out_valid=0 immediately.
  - Hold out_ready=0 for 5 cycles in DONE -> result stable throughout.
